uc_fsm: RTL and testbench

- Multi-cycle control unit that drives every control input of the bus-based datapath (processing unit): bus-driver enables, register load enables, RF controls and ALU function.
- Sequences fetch, PC increment, decode, operand read, execute and write-back.
- Owns the instruction-memory handshake and feeds memory data (or the PC step constant) onto the datapath `rd_data` input.
- Supported instructions: RV32I ADD, SUB (opcode 0110011) and ADDI (opcode 0010011). Anything else traps.

---
 rtl/uc_pkg.sv | 59 +++++
 rtl/uc_decode.sv | 71 +++++++
 rtl/uc_fsm.sv | 146 ++++++++++++++
 tb/tb_uc_fsm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared types for the multi-cycle control unit.
//   state_t  : control FSM states
//   rd_src_t : source of the datapath rd_data input
//   ctrl_t   : every datapath control signal driven by the FSM
//   is_legal : true for the supported subset (ADD, SUB, ADDI)
package uc_pkg;

  typedef enum logic [3:0] {
    S_FETCH_REQ,
    S_FETCH_LD,
    S_INC_B,
    S_INC_W,
    S_DECODE,
    S_RS1,
    S_RS2,
    S_IMM,
    S_EXEC_WB,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [1:0] {
    RD_ZERO,
    RD_HOLD,
    RD_STEP
  } rd_src_t;

  typedef struct packed {
    logic       mem_req;
    logic       ir_en;
    logic       a_en;
    logic       b_en;
    logic       pc_en;
    logic       immgen_bus_en;
    logic       alu_bus_en;
    logic       pc_bus_en;
    logic       rf_bus_en;
    logic       rd_bus_en;
    logic       rf_wen;
    logic       rf_ren;
    logic       sel_alu_func;
    logic [1:0] rf_addr_sel;
    rd_src_t    rd_src;
  } ctrl_t;

  function automatic logic is_legal(input logic [31:0] ins);
    logic r_ok, i_ok;
    r_ok = (ins[6:0] == OP_R) && (ins[14:12] == 3'b000) &&
           ((ins[31:25] == 7'b0000000) || (ins[31:25] == 7'b0100000));
    i_ok = (ins[6:0] == OP_IMM) && (ins[14:12] == 3'b000);
    return r_ok || i_ok;
  endfunction

endpackage

// File: rtl/uc_decode.sv
// Moore output decode: maps the current state and IR contents to the
// datapath control bundle. Purely combinational.
//   state : current FSM state
//   instr : IR contents (fields rd/rs1/rs2/funct7 used here)
//   ctrl  : control bundle for the datapath
module uc_decode
  import uc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  state_t          state,
  input  logic [XLEN-1:0] instr,
  output ctrl_t           ctrl
);

  // instr bits that no decode depends on
  logic unused_instr;
  assign unused_instr = ^{instr[XLEN-1:31], instr[29:22], instr[19:17], instr[14:9]};

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH_REQ: begin
        ctrl.pc_bus_en = 1'b1;
        ctrl.a_en      = 1'b1;
        ctrl.mem_req   = 1'b1;
      end
      S_FETCH_LD: begin
        ctrl.rd_bus_en = 1'b1;
        ctrl.rd_src    = RD_HOLD;
        ctrl.ir_en     = 1'b1;
      end
      S_INC_B: begin
        ctrl.rd_bus_en    = 1'b1;
        ctrl.rd_src       = RD_STEP;
        ctrl.b_en         = 1'b1;
        ctrl.sel_alu_func = ALU_ADD;
      end
      S_INC_W: begin
        ctrl.alu_bus_en   = 1'b1;
        ctrl.pc_en        = 1'b1;
        ctrl.sel_alu_func = ALU_ADD;
      end
      S_RS1: begin
        ctrl.rf_addr_sel = instr[16:15];
        ctrl.rf_ren      = 1'b1;
        ctrl.rf_bus_en   = 1'b1;
        ctrl.a_en        = 1'b1;
      end
      S_RS2: begin
        ctrl.rf_addr_sel = instr[21:20];
        ctrl.rf_ren      = 1'b1;
        ctrl.rf_bus_en   = 1'b1;
        ctrl.b_en        = 1'b1;
      end
      S_IMM: begin
        ctrl.immgen_bus_en = 1'b1;
        ctrl.b_en          = 1'b1;
      end
      S_EXEC_WB: begin
        ctrl.alu_bus_en   = 1'b1;
        ctrl.rf_addr_sel  = instr[8:7];
        // instr[30] distinguishes SUB from ADD; ADDI always adds
        ctrl.sel_alu_func = (instr[6:0] == OP_R) ? instr[30] : ALU_ADD;
        ctrl.rf_wen       = (instr[11:7] != 5'd0);
      end
      default: ctrl = '0; // DECODE, TRAP
    endcase
  end

endmodule

// File: rtl/uc_fsm.sv
// Multi-cycle control unit for the bus-based datapath. Sequences fetch,
// PC increment, decode, operand read, execute and write-back for
// ADD/SUB/ADDI; anything else (or a fetch timeout) traps until reset.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   instr             : IR contents from the datapath
//   ALU_carry         : ALU carry (not used for sequencing)
//   mem_rdata/mem_ack : instruction word and its valid strobe
//   mem_req           : fetch request (address on databus)
//   rd_data           : held fetch word or PC_STEP onto the datapath
//   *_en, rf_*        : datapath register enables and bus-driver selects
//   sel_alu_func      : 0 = ADD, 1 = SUB
//   illegal           : sticky trap flag
//   instret           : retired-instruction counter
module uc_fsm
  import uc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PC_STEP     = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr,
  input  logic            ALU_carry,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic [XLEN-1:0] rd_data,
  output logic            sel_alu_func,
  output logic            ir_en,
  output logic            a_en,
  output logic            b_en,
  output logic            pc_en,
  output logic            immgen_bus_en,
  output logic            ALU_bus_en,
  output logic            pc_bus_en,
  output logic            rf_bus_en,
  output logic            rd_bus_en,
  output logic            rf_wen,
  output logic            rf_ren,
  output logic [1:0]      rf_addr_sel,
  output logic            illegal,
  output logic [31:0]     instret
);

  state_t          state, state_n;
  logic [XLEN-1:0] hold;
  logic [31:0]     wait_cnt;
  logic            set_illegal;
  ctrl_t           ctrl_dec, ctrl;

  logic unused_carry;
  assign unused_carry = ALU_carry;

  uc_decode #(.XLEN(XLEN)) u_decode (
    .state (state),
    .instr (instr),
    .ctrl  (ctrl_dec)
  );

  // Next-state logic
  always_comb begin
    state_n     = state;
    set_illegal = 1'b0;
    unique case (state)
      S_FETCH_REQ: begin
        // ack beats a timeout expiring in the same cycle
        if (mem_ack) begin
          state_n = S_FETCH_LD;
        end else if ((MEM_TIMEOUT != 0) && (wait_cnt == 32'(MEM_TIMEOUT - 1))) begin
          state_n     = S_TRAP;
          set_illegal = 1'b1;
        end
      end
      S_FETCH_LD: state_n = S_INC_B;
      S_INC_B:    state_n = S_INC_W;
      S_INC_W:    state_n = S_DECODE;
      S_DECODE: begin
        if (is_legal(instr[31:0])) begin
          state_n = S_RS1;
        end else begin
          state_n     = S_TRAP;
          set_illegal = 1'b1;
        end
      end
      S_RS1:     state_n = (instr[6:0] == OP_R) ? S_RS2 : S_IMM;
      S_RS2:     state_n = S_EXEC_WB;
      S_IMM:     state_n = S_EXEC_WB;
      S_EXEC_WB: state_n = S_FETCH_REQ;
      S_TRAP:    state_n = S_TRAP;
      default:   state_n = S_FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH_REQ;
      illegal  <= 1'b0;
      instret  <= '0;
      hold     <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (set_illegal) illegal <= 1'b1;
      if (state == S_FETCH_REQ) begin
        if (mem_ack) begin
          hold     <= mem_rdata;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 32'd1;
        end
      end
      if (state == S_EXEC_WB) instret <= instret + 32'd1;
    end
  end

  // Reset forces every control output low in the reset cycle itself,
  // regardless of the state the register currently holds.
  assign ctrl = rst ? '0 : ctrl_dec;

  always_comb begin
    rd_data = '0;
    unique case (ctrl.rd_src)
      RD_HOLD: rd_data = hold;
      RD_STEP: rd_data = XLEN'(PC_STEP);
      default: rd_data = '0;
    endcase
  end

  assign mem_req       = ctrl.mem_req;
  assign sel_alu_func  = ctrl.sel_alu_func;
  assign ir_en         = ctrl.ir_en;
  assign a_en          = ctrl.a_en;
  assign b_en          = ctrl.b_en;
  assign pc_en         = ctrl.pc_en;
  assign immgen_bus_en = ctrl.immgen_bus_en;
  assign ALU_bus_en    = ctrl.alu_bus_en;
  assign pc_bus_en     = ctrl.pc_bus_en;
  assign rf_bus_en     = ctrl.rf_bus_en;
  assign rd_bus_en     = ctrl.rd_bus_en;
  assign rf_wen        = ctrl.rf_wen;
  assign rf_ren        = ctrl.rf_ren;
  assign rf_addr_sel   = ctrl.rf_addr_sel;

endmodule

// File: tb/tb_uc_fsm.sv
// Directed bench for uc_fsm. A small bus/register datapath model is
// wrapped around the control unit so architectural results (PC, RF) can
// be checked against hand-computed values.
module tb_uc_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        ALU_carry;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic [31:0] rd_data;
  logic        sel_alu_func, ir_en, a_en, b_en, pc_en;
  logic        immgen_bus_en, ALU_bus_en, pc_bus_en, rf_bus_en, rd_bus_en;
  logic        rf_wen, rf_ren;
  logic [1:0]  rf_addr_sel;
  logic        illegal;
  logic [31:0] instret;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uc_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .ALU_carry(ALU_carry),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req),
    .rd_data(rd_data), .sel_alu_func(sel_alu_func), .ir_en(ir_en),
    .a_en(a_en), .b_en(b_en), .pc_en(pc_en), .immgen_bus_en(immgen_bus_en),
    .ALU_bus_en(ALU_bus_en), .pc_bus_en(pc_bus_en), .rf_bus_en(rf_bus_en),
    .rd_bus_en(rd_bus_en), .rf_wen(rf_wen), .rf_ren(rf_ren),
    .rf_addr_sel(rf_addr_sel), .illegal(illegal), .instret(instret)
  );

  // ---- datapath model ----
  logic [31:0] m_pc, m_a, m_b, m_ir, bus, alu, imm;
  logic [31:0] m_rf [4];
  logic        rf_load;

  assign instr     = m_ir;
  assign ALU_carry = 1'b0;
  assign alu       = sel_alu_func ? (m_a - m_b) : (m_a + m_b);
  assign imm       = {{20{m_ir[31]}}, m_ir[31:20]};
  assign bus = pc_bus_en     ? m_pc :
               rd_bus_en     ? rd_data :
               ALU_bus_en    ? alu :
               rf_bus_en     ? m_rf[rf_addr_sel] :
               immgen_bus_en ? imm : 32'd0;

  always @(posedge clk) begin
    if (rf_load) begin
      m_rf[0] <= 0; m_rf[1] <= 0; m_rf[2] <= 32'd7; m_rf[3] <= 0;
    end
    if (rst) begin
      m_pc <= 0; m_a <= 0; m_b <= 0; m_ir <= 0;
    end else begin
      if (a_en)  m_a  <= bus;
      if (b_en)  m_b  <= bus;
      if (pc_en) m_pc <= bus;
      if (ir_en) m_ir <= bus;
      if (rf_wen && rf_addr_sel != 2'd0) m_rf[rf_addr_sel] <= bus;
    end
  end

  // At most one bus driver per cycle, every cycle.
  always @(negedge clk) begin
    checks++;
    assert ($countones({immgen_bus_en, ALU_bus_en, pc_bus_en, rf_bus_en, rd_bus_en}) <= 1)
    else begin
      failures++;
      $error("FAIL bus_onehot: observed %b expected at most one set",
             {immgen_bus_en, ALU_bus_en, pc_bus_en, rf_bus_en, rd_bus_en});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {15'd0, mem_req, ir_en, a_en, b_en, pc_en, immgen_bus_en, ALU_bus_en,
            pc_bus_en, rf_bus_en, rd_bus_en, rf_wen, rf_ren, sel_alu_func,
            rf_addr_sel, 2'd0} | rd_data;
  endfunction

  // Called #1 after an edge with the DUT in FETCH_REQ. Acks immediately and
  // runs the full 8-cycle instruction, returning to FETCH_REQ.
  task automatic run_instr(input logic [31:0] w, output logic saw_wen, output logic saw_sub);
    saw_wen = 1'b0;
    saw_sub = 1'b0;
    mem_rdata = w;
    mem_ack   = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("fetch_ld_rd_data", rd_data, w);
    for (int i = 0; i < 7; i++) begin
      if (i == 1) chk("inc_b_step", rd_data, 32'd4);
      if (rf_wen) saw_wen = 1'b1;
      if (ALU_bus_en && !pc_en) saw_sub = sel_alu_func;
      @(posedge clk); #1;
    end
    chk("back_to_fetch", {31'd0, mem_req}, 32'd1);
  endtask

  logic wen, sub;
  logic any_req;

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0; rf_load = 1'b1;

    // ---- reset ----
    repeat (2) @(posedge clk);
    #1;
    rf_load = 1'b0;
    chk("rst_outputs_zero", all_outs(), 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    rst = 1'b0;
    #1;
    chk("fetch_req_en", {29'd0, mem_req, pc_bus_en, a_en}, 32'd7);

    // ---- ADDI x1,x0,5 ----
    run_instr(32'h00500093, wen, sub);
    chk("addi_x1", m_rf[1], 32'd5);
    chk("addi_pc", m_pc, 32'd4);
    chk("addi_instret", instret, 32'd1);
    chk("addi_wen", {31'd0, wen}, 32'd1);

    // ---- ADD x3,x1,x2 ----
    run_instr(32'h002081B3, wen, sub);
    chk("add_x3", m_rf[3], 32'd12);
    chk("add_sel", {31'd0, sub}, 32'd0);
    chk("add_pc", m_pc, 32'd8);

    // ---- SUB x3,x1,x2 ----
    run_instr(32'h402081B3, wen, sub);
    chk("sub_sel", {31'd0, sub}, 32'd1);
    chk("sub_x3", m_rf[3], 32'hFFFFFFFE);

    // ---- ADDI x0,x0,1 ----
    run_instr(32'h00100013, wen, sub);
    chk("x0_no_wen", {31'd0, wen}, 32'd0);
    chk("x0_instret", instret, 32'd4);
    chk("x0_pc", m_pc, 32'd16);

    // ---- JAL traps ----
    mem_rdata = 32'h0000006F; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("jal_decode_not_yet", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1;
    chk("jal_illegal", {31'd0, illegal}, 32'd1);
    any_req = 1'b0;
    repeat (4) begin
      if (mem_req) any_req = 1'b1;
      @(posedge clk); #1;
    end
    chk("trap_no_req", {31'd0, any_req}, 32'd0);
    chk("trap_outs_zero", all_outs(), 32'd0);
    chk("trap_instret", instret, 32'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("trap_rst_illegal", {31'd0, illegal}, 32'd0);
    chk("trap_rst_req", {31'd0, mem_req}, 32'd1);
    chk("trap_rst_instret", instret, 32'd0);

    // ---- fetch timeout ----
    repeat (15) begin @(posedge clk); #1; end
    chk("to_15_illegal", {31'd0, illegal}, 32'd0);
    chk("to_15_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    chk("to_16_illegal", {31'd0, illegal}, 32'd1);
    chk("to_16_req", {31'd0, mem_req}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- ack in the 16th wait cycle wins ----
    repeat (15) begin @(posedge clk); #1; end
    run_instr(32'h00900093, wen, sub);
    chk("late_ack_illegal", {31'd0, illegal}, 32'd0);
    chk("late_ack_x1", m_rf[1], 32'd9);
    chk("late_ack_instret", instret, 32'd1);
    chk("late_ack_pc", m_pc, 32'd4);

    // ---- reset in RS2 ----
    mem_rdata = 32'h002081B3; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("rs2_state", {30'd0, rf_bus_en, b_en}, 32'd3);
    chk("rs2_addr", {30'd0, rf_addr_sel}, 32'd2);
    rst = 1'b1;
    #1;
    chk("rs2_rst_outs_zero", all_outs(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rs2_rst_req", {31'd0, mem_req}, 32'd1);
    chk("rs2_rst_instret", instret, 32'd0);
    chk("rs2_rst_illegal", {31'd0, illegal}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
